// File: rtl/mips_pkg.sv
// Shared definitions for the MEM-stage data-memory slave: state encoding and word geometry.
package mips_pkg;
  localparam int WORD_W   = 32;
  localparam int BYTE_OFS = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit word storage: synchronous write, combinational read, power-on contents mem[i] = i.
module dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  function automatic logic [DEPTH-1:0][WORD_W-1:0] init_fill();
    logic [DEPTH-1:0][WORD_W-1:0] f;
    for (int i = 0; i < DEPTH; i++) f[i] = WORD_W'(i);
    return f;
  endfunction

  // Contents survive rst; only the power-on value is defined.
  logic [DEPTH-1:0][WORD_W-1:0] mem = init_fill();

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, stalls the pipeline for LATENCY
// cycles, then completes it (write, read data, or error pulse).
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_memread,
  input  logic              m_memwrite,
  input  logic [31:0]       m_addr,
  input  logic [31:0]       m_wdata,
  output logic              m_stall,
  output logic              m_done,
  output logic [31:0]       m_rdata,
  output logic              m_err,
  output state_t            dbg_state
);

  // Handshake: a request (m_memread|m_memwrite) is accepted in the IDLE cycle it is seen; the
  // master holds the stage while m_stall=1; the completion cycle has m_stall=0 and m_done=1.
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [WORD_W-BYTE_OFS-1:0] DEPTH_W  = (WORD_W-BYTE_OFS)'(DEPTH);
  localparam logic [3:0]                 CNT_INIT = 4'(LATENCY - 1);

  state_t              state, state_nx;
  logic [3:0]          cnt;
  logic [IDX_W-1:0]    idx_q;
  logic [WORD_W-1:0]   wdata_q, rdata_q, mem_rdata;
  logic                load_q, err_q;
  logic                req, illegal, accept, complete, mem_we;

  assign req = m_memread | m_memwrite;

  // Range check uses the full word address so high bits cannot alias into the array.
  assign illegal = (m_addr[BYTE_OFS-1:0] != '0)
                || (m_addr[WORD_W-1:BYTE_OFS] >= DEPTH_W)
                || (m_memread && m_memwrite);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    complete = 1'b0;
    m_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept   = 1'b1;
          m_stall  = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          m_stall = 1'b1;
        end else begin
          complete = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Reset wins over acceptance and completion in the same cycle.
    if (rst) begin
      accept   = 1'b0;
      complete = 1'b0;
      m_stall  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 4'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        cnt     <= CNT_INIT;
        idx_q   <= m_addr[BYTE_OFS +: IDX_W];
        wdata_q <= m_wdata;
        load_q  <= m_memread;
        err_q   <= illegal;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (complete && (load_q || err_q)) rdata_q <= err_q ? '0 : mem_rdata;
    end
  end

  assign mem_we    = complete && !load_q && !err_q;
  assign m_done    = complete;
  assign m_err     = complete && err_q;
  assign m_rdata   = complete ? (err_q ? '0 : (load_q ? mem_rdata : rdata_q)) : rdata_q;
  assign dbg_state = state;

  dmem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on a LATENCY=2 instance, hand sequences for
// reset-during-access and back-to-back LATENCY=1 loads.
module tb_dmem_responder;
  import mips_pkg::*;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_memread = 1'b0, m_memwrite = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic        m_stall, m_done, m_err;
  logic [31:0] m_rdata;
  state_t      dbg_state;

  logic        r1 = 1'b0, w1 = 1'b0;
  logic [31:0] a1 = '0, wd1 = '0;
  logic        s1, d1, e1;
  logic [31:0] rd1;
  state_t      st1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  vec_t vecs[15];

  // Clock / DUTs
  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(128), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .m_memread(m_memread), .m_memwrite(m_memwrite),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_stall(m_stall), .m_done(m_done),
    .m_rdata(m_rdata), .m_err(m_err), .dbg_state(dbg_state)
  );

  dmem_responder #(.DEPTH(128), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .m_memread(r1), .m_memwrite(w1),
    .m_addr(a1), .m_wdata(wd1), .m_stall(s1), .m_done(d1),
    .m_rdata(rd1), .m_err(e1), .dbg_state(st1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic exp_err,
                              input logic [31:0] exp_rdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  // Driver: one access on the LATENCY=2 instance; inputs scrambled after acceptance.
  task automatic do_access(input vec_t v, input string name);
    int   cycles;
    logic seen;
    logic [31:0] exp_rd;
    exp_q.push_back(v.exp_rdata);
    @(posedge clk); #1;
    m_memread = v.rd; m_memwrite = v.wr; m_addr = v.addr; m_wdata = v.wdata;
    @(negedge clk);
    check({name, "_accept_stall"}, 32'(m_stall), 32'd1);
    check({name, "_accept_done"}, 32'(m_done), 32'd0);
    @(posedge clk); #1;
    m_memread = 1'b0; m_memwrite = 1'b0;
    m_addr = $urandom; m_wdata = $urandom;
    cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cycles++;
      if (m_done) seen = 1'b1;
      else check({name, "_busy_stall"}, 32'(m_stall), 32'd1);
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(cycles), 32'd2);
    check({name, "_done_stall"}, 32'(m_stall), 32'd0);
    check({name, "_err"}, 32'(m_err), 32'(v.exp_err));
    exp_rd = exp_q.pop_front();
    check({name, "_rdata"}, m_rdata, exp_rd);
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 32'h10,       32'h0,        0, 32'd4);
    vecs[1]  = mk(0, 1, 32'h20,       32'hDEADBEEF, 0, 32'd4);
    vecs[2]  = mk(1, 0, 32'h20,       32'h0,        0, 32'hDEADBEEF);
    vecs[3]  = mk(1, 0, 32'h13,       32'h0,        1, 32'd0);
    vecs[4]  = mk(0, 1, 32'h200,      32'h1234,     1, 32'd0);
    vecs[5]  = mk(1, 0, 32'h04,       32'h0,        0, 32'd1);
    vecs[6]  = mk(1, 0, 32'h00,       32'h0,        0, 32'd0);
    vecs[7]  = mk(1, 1, 32'h0C,       32'hFFFF,     1, 32'd0);
    vecs[8]  = mk(1, 0, 32'h0C,       32'h0,        0, 32'd3);
    vecs[9]  = mk(1, 0, 32'h1FC,      32'h0,        0, 32'h7F);
    vecs[10] = mk(0, 1, 32'h1FC,      32'hA5A5A5A5, 0, 32'h7F);
    vecs[11] = mk(1, 0, 32'h1FC,      32'h0,        0, 32'hA5A5A5A5);
    vecs[12] = mk(0, 1, 32'h22,       32'h1111,     1, 32'd0);
    vecs[13] = mk(1, 0, 32'h20,       32'h0,        0, 32'hDEADBEEF);
    vecs[14] = mk(1, 0, 32'hFFFFFFFC, 32'h0,        1, 32'd0);

    // Reset block
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_stall", 32'(m_stall), 32'd0);
      check("reset_done", 32'(m_done), 32'd0);
      check("reset_err", 32'(m_err), 32'd0);
      check("reset_rdata", m_rdata, 32'd0);
      check("reset_state", 32'(dbg_state), 32'(IDLE));
    end

    for (int i = 0; i < 15; i++) do_access(vecs[i], $sformatf("vec%0d", i));

    // Store cut short by rst in its second cycle: no completion, no write.
    @(posedge clk); #1;
    m_memwrite = 1'b1; m_addr = 32'h08; m_wdata = 32'h55;
    @(negedge clk);
    check("rstseq_accept_stall", 32'(m_stall), 32'd1);
    @(posedge clk); #1;
    m_memwrite = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rstseq_rst_stall", 32'(m_stall), 32'd0);
    check("rstseq_rst_done", 32'(m_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstseq_state_idle", 32'(dbg_state), 32'(IDLE));
    check("rstseq_rdata_cleared", m_rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("rstseq_no_done", 32'(m_done), 32'd0);
      check("rstseq_no_stall", 32'(m_stall), 32'd0);
      @(negedge clk);
    end
    do_access(mk(1, 0, 32'h08, 32'h0, 0, 32'd2), "rstseq_load");

    // LATENCY=1: two loads held by stall, address changed during the second access.
    @(posedge clk); #1;
    r1 = 1'b1; a1 = 32'h04;
    @(negedge clk);
    check("l1_t0_stall", 32'(s1), 32'd1);
    check("l1_t0_done", 32'(d1), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("l1_t1_done", 32'(d1), 32'd1);
    check("l1_t1_stall", 32'(s1), 32'd0);
    check("l1_t1_rdata", rd1, 32'd1);
    @(posedge clk); #1;
    a1 = 32'h0C;
    @(negedge clk);
    check("l1_t2_stall", 32'(s1), 32'd1);
    check("l1_t2_done", 32'(d1), 32'd0);
    @(posedge clk); #1;
    a1 = 32'h20;
    @(negedge clk);
    check("l1_t3_done", 32'(d1), 32'd1);
    check("l1_t3_rdata", rd1, 32'd3);
    check("l1_t3_err", 32'(e1), 32'd0);
    @(posedge clk); #1;
    r1 = 1'b0;
    @(negedge clk);
    check("l1_t4_done", 32'(d1), 32'd0);
    check("l1_t4_stall", 32'(s1), 32'd0);
    check("l1_t4_rdata_hold", rd1, 32'd3);

    // Report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
